// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: register map, STATUS layout and engine states.
package spi_pkg;

  localparam int unsigned SPI_DW     = 32;
  localparam int unsigned SPI_BYTE_W = 8;
  localparam int unsigned SPI_CNT_W  = 3;
  localparam int unsigned SPI_STAT_W = 4;

  localparam logic [1:0] SPI_REG_DATA   = 2'd0;
  localparam logic [1:0] SPI_REG_STATUS = 2'd1;

  localparam int unsigned ST_RX_VALID  = 0;
  localparam int unsigned ST_TX_LOADED = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_BUSY      = 3;

  typedef struct packed {
    logic busy;
    logic overrun;
    logic tx_loaded;
    logic rx_valid;
  } spi_status_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser bringing an asynchronous SPI pin into the clk domain.
module spi_sync2 #(
  parameter logic RST = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= RST;
      q    <= RST;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI responder with memory-mapped DATA/STATUS registers; all SPI pins are
// oversampled in clk, which must run at least 4x sclk.
module spi_slave
  import spi_pkg::*;
#(
  parameter logic                  CPOL = 1'b0,
  parameter logic                  CPHA = 1'b0,
  parameter logic [SPI_BYTE_W-1:0] PAD  = 8'hFF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  output logic              ready,
  input  logic [SPI_DW-1:0] addr,
  input  logic [3:0]        wstrb,
  input  logic [SPI_DW-1:0] wdata,
  output logic [SPI_DW-1:0] rdata,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              irq
);

  logic sclk_s, ss_n_s, mosi_s;
  logic sclk_d, ss_n_d;

  spi_sync2 #(.RST(CPOL)) u_sync_sclk (.clk(clk), .resetn(resetn), .d(sclk), .q(sclk_s));
  spi_sync2 #(.RST(1'b0)) u_sync_ss   (.clk(clk), .resetn(resetn), .d(ss_n), .q(ss_n_s));
  spi_sync2 #(.RST(1'b0)) u_sync_mosi (.clk(clk), .resetn(resetn), .d(mosi), .q(mosi_s));

  spi_state_e               state;
  logic                     armed;
  logic                     busy;
  logic [SPI_CNT_W-1:0]     bit_cnt;
  logic [SPI_BYTE_W-2:0]    tx_shift;
  logic [SPI_BYTE_W-2:0]    rx_shift;
  logic [SPI_BYTE_W-1:0]    tx_buf;
  logic                     tx_loaded;
  logic [SPI_BYTE_W-1:0]    rx_data;
  logic                     rx_valid;
  logic                     overrun;

  // Edge and bus decode
  logic lead_e, trail_e, sample_e, launch_e, ss_fall, ss_rise;
  logic acc, rd, wr, data_rd, data_wr, ovr_clr, byte_done;
  logic [SPI_BYTE_W-1:0] ld_byte;

  assign lead_e   = (sclk_d == CPOL) && (sclk_s != CPOL);
  assign trail_e  = (sclk_d != CPOL) && (sclk_s == CPOL);
  assign sample_e = CPHA ? trail_e : lead_e;
  assign launch_e = CPHA ? lead_e : trail_e;
  assign ss_fall  = ss_n_d && !ss_n_s;
  assign ss_rise  = !ss_n_d && ss_n_s;

  assign acc     = valid && !ready;
  assign wr      = acc && (|wstrb);
  assign rd      = acc && !(|wstrb);
  assign data_rd = rd && (addr[3:2] == SPI_REG_DATA);
  assign data_wr = wr && (addr[3:2] == SPI_REG_DATA);
  assign ovr_clr = wr && (addr[3:2] == SPI_REG_STATUS) && wdata[ST_OVERRUN];

  assign byte_done = (state == ACTIVE) && !ss_rise && sample_e
                     && (bit_cnt == SPI_CNT_W'(SPI_BYTE_W - 1));
  assign ld_byte   = tx_loaded ? tx_buf : PAD;

  spi_status_t status;
  assign status = '{busy: busy, overrun: overrun, tx_loaded: tx_loaded, rx_valid: rx_valid};

  logic [SPI_DW-1:0] rd_val;
  always_comb begin
    rd_val = '0;
    case (addr[3:2])
      SPI_REG_DATA:   rd_val = {{(SPI_DW - SPI_BYTE_W){1'b0}}, rx_data};
      SPI_REG_STATUS: rd_val = {{(SPI_DW - SPI_STAT_W){1'b0}}, status};
      default:        rd_val = '0;
    endcase
  end

  // Flag update: clears apply first so a coinciding new event wins
  logic rx_valid_nx, overrun_nx;
  always_comb begin
    rx_valid_nx = rx_valid;
    overrun_nx  = overrun;
    if (data_rd) rx_valid_nx = 1'b0;
    if (ovr_clr) overrun_nx  = 1'b0;
    if (byte_done) begin
      rx_valid_nx = 1'b1;
      if (rx_valid && !data_rd) overrun_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk_d    <= CPOL;
      ss_n_d    <= 1'b0;
      state     <= IDLE;
      armed     <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      tx_buf    <= '0;
      tx_loaded <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      ready     <= 1'b0;
      rdata     <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      sclk_d   <= sclk_s;
      ss_n_d   <= ss_n_s;
      ready    <= acc;
      rx_valid <= rx_valid_nx;
      overrun  <= overrun_nx;
      irq      <= rx_valid_nx | overrun_nx;
      if (ss_n_s) armed <= 1'b1;
      if (byte_done) rx_data <= {rx_shift, mosi_s};
      if (rd) rdata <= rd_val;

      case (state)
        IDLE: begin
          if (ss_fall && armed) begin
            state   <= ACTIVE;
            bit_cnt <= '0;
            miso_oe <= 1'b1;
            busy    <= 1'b1;
            if (!CPHA) begin
              tx_shift  <= ld_byte[SPI_BYTE_W-2:0];
              miso      <= ld_byte[SPI_BYTE_W-1];
              tx_loaded <= 1'b0;
            end
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state   <= IDLE;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            busy    <= 1'b0;
          end else begin
            // bit_cnt wraps 7 -> 0 on its own at byte completion
            if (sample_e) begin
              rx_shift <= {rx_shift[SPI_BYTE_W-3:0], mosi_s};
              bit_cnt  <= bit_cnt + SPI_CNT_W'(1);
            end
            if (launch_e) begin
              if (bit_cnt == '0) begin
                tx_shift  <= ld_byte[SPI_BYTE_W-2:0];
                miso      <= ld_byte[SPI_BYTE_W-1];
                tx_loaded <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[SPI_BYTE_W-3:0], 1'b0};
                miso     <= tx_shift[SPI_BYTE_W-2];
              end
            end
          end
        end
      endcase

      // Bus write lands after any byte load, so the load sees pre-write state
      if (data_wr) begin
        tx_buf    <= wdata[SPI_BYTE_W-1:0];
        tx_loaded <= 1'b1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, addr[31:4], addr[1:0], wdata[31:8]};

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 instance and a CPOL=1/CPHA=1 instance driven by a bit-banged master.
module tb_spi_slave;

  localparam logic [1:0] POL = 2'b10;
  localparam logic [1:0] PHA = 2'b10;

  logic        clk, resetn;
  logic [1:0]  valid, ready, sclk, ss_n, mosi, miso, miso_oe, irq;
  logic [31:0] addr [2];
  logic [31:0] wdata[2];
  logic [31:0] rdata[2];
  logic [3:0]  wstrb[2];

  int tests = 0;
  int failed = 0;

  spi_slave #(.CPOL(1'b0), .CPHA(1'b0), .PAD(8'hFF)) dut0 (
    .clk(clk), .resetn(resetn), .valid(valid[0]), .ready(ready[0]), .addr(addr[0]),
    .wstrb(wstrb[0]), .wdata(wdata[0]), .rdata(rdata[0]), .sclk(sclk[0]), .ss_n(ss_n[0]),
    .mosi(mosi[0]), .miso(miso[0]), .miso_oe(miso_oe[0]), .irq(irq[0]));

  spi_slave #(.CPOL(1'b1), .CPHA(1'b1), .PAD(8'hFF)) dut1 (
    .clk(clk), .resetn(resetn), .valid(valid[1]), .ready(ready[1]), .addr(addr[1]),
    .wstrb(wstrb[1]), .wdata(wdata[1]), .rdata(rdata[1]), .sclk(sclk[1]), .ss_n(ss_n[1]),
    .mosi(mosi[1]), .miso(miso[1]), .miso_oe(miso_oe[1]), .irq(irq[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input int u, input logic [3:0] a, input logic we,
                     input logic [31:0] wd, output logic [31:0] rd);
    logic got;
    got       = 1'b0;
    rd        = '0;
    addr[u]   = {28'b0, a};
    wstrb[u]  = we ? 4'hF : 4'h0;
    wdata[u]  = wd;
    valid[u]  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (ready[u]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      failed++;
      $display("FAIL bus_timeout: got no ready, required ready within 8 clk");
    end
    rd       = rdata[u];
    valid[u] = 1'b0;
    wstrb[u] = 4'h0;
    wait_clk(1);
  endtask

  // Bit-banged master with sclk = clk/8; returns what it sampled on miso
  task automatic spi_xfer(input int u, input logic [7:0] tx, input int nbits,
                          input bit keep_ss, output logic [7:0] rx);
    logic pol, pha;
    pol = POL[u];
    pha = PHA[u];
    rx  = '0;
    ss_n[u] = 1'b0;
    if (!pha) mosi[u] = tx[7];
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      sclk[u] = !pol;
      if (pha) mosi[u] = tx[7-i];
      else     rx = {rx[6:0], miso[u]};
      wait_clk(4);
      sclk[u] = pol;
      if (pha)        rx = {rx[6:0], miso[u]};
      else if (i < 7) mosi[u] = tx[6-i];
      wait_clk(4);
    end
    if (!keep_ss) begin
      ss_n[u] = 1'b1;
      wait_clk(6);
    end
  endtask

  typedef struct {
    int         u;
    bit         load;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] rd;
    logic [7:0]  got;

    vecs[0] = '{u: 0, load: 1'b1, tx: 8'hA5, mo: 8'h3C, exp_miso: 8'hA5, exp_status: 32'h1};
    vecs[1] = '{u: 0, load: 1'b0, tx: 8'h00, mo: 8'h00, exp_miso: 8'hFF, exp_status: 32'h1};
    vecs[2] = '{u: 1, load: 1'b1, tx: 8'h5A, mo: 8'hC3, exp_miso: 8'h5A, exp_status: 32'h1};
    vecs[3] = '{u: 0, load: 1'b1, tx: 8'h96, mo: 8'h69, exp_miso: 8'h96, exp_status: 32'h1};

    resetn = 1'b0;
    valid  = '0;
    ss_n   = 2'b11;
    sclk   = POL;
    mosi   = '0;
    for (int u = 0; u < 2; u++) begin
      addr[u] = '0; wdata[u] = '0; wstrb[u] = '0;
    end
    wait_clk(4);
    chk("reset_out0", {31'b0, ready[0]} | rdata[0] | {30'b0, miso[0], miso_oe[0]} | {31'b0, irq[0]}, 32'h0);
    chk("reset_out1", {31'b0, ready[1]} | rdata[1] | {30'b0, miso[1], miso_oe[1]} | {31'b0, irq[1]}, 32'h0);
    resetn = 1'b1;
    wait_clk(6);

    for (int k = 0; k < 4; k++) begin
      if (vecs[k].load) begin
        bus(vecs[k].u, 4'h0, 1'b1, {24'b0, vecs[k].tx}, rd);
        bus(vecs[k].u, 4'h4, 1'b0, 32'h0, rd);
        chk($sformatf("v%0d_status_loaded", k), rd, 32'h2);
      end
      spi_xfer(vecs[k].u, vecs[k].mo, 8, 1'b0, got);
      chk($sformatf("v%0d_miso", k), {24'b0, got}, {24'b0, vecs[k].exp_miso});
      chk($sformatf("v%0d_irq", k), {31'b0, irq[vecs[k].u]}, 32'h1);
      bus(vecs[k].u, 4'h4, 1'b0, 32'h0, rd);
      chk($sformatf("v%0d_status", k), rd, vecs[k].exp_status);
      bus(vecs[k].u, 4'h0, 1'b0, 32'h0, rd);
      chk($sformatf("v%0d_rx_data", k), rd, {24'b0, vecs[k].mo});
      chk($sformatf("v%0d_irq_clr", k), {31'b0, irq[vecs[k].u]}, 32'h0);
    end

    // Overrun: two bytes without a DATA read
    spi_xfer(0, 8'h11, 8, 1'b0, got);
    spi_xfer(0, 8'h22, 8, 1'b0, got);
    bus(0, 4'h4, 1'b0, 32'h0, rd);
    chk("ovr_status", rd, 32'h5);
    bus(0, 4'h4, 1'b1, 32'h4, rd);
    bus(0, 4'h4, 1'b0, 32'h0, rd);
    chk("ovr_cleared", rd, 32'h1);
    chk("ovr_irq_rxv", {31'b0, irq[0]}, 32'h1);
    bus(0, 4'h0, 1'b0, 32'h0, rd);
    chk("ovr_data", rd, 32'h22);
    bus(0, 4'h4, 1'b0, 32'h0, rd);
    chk("ovr_status_clr", rd, 32'h0);

    // Abort after 5 bits, then a clean byte
    spi_xfer(0, 8'hAA, 5, 1'b0, got);
    bus(0, 4'h4, 1'b0, 32'h0, rd);
    chk("abort_status", rd, 32'h0);
    chk("abort_pins", {30'b0, miso_oe[0], miso[0]}, 32'h0);
    spi_xfer(0, 8'h81, 8, 1'b0, got);
    chk("after_abort_miso", {24'b0, got}, 32'hFF);
    bus(0, 4'h0, 1'b0, 32'h0, rd);
    chk("after_abort_data", rd, 32'h81);

    // Reset mid-byte with ss_n held low
    spi_xfer(0, 8'h77, 8, 1'b0, got);
    bus(0, 4'h4, 1'b0, 32'h0, rd);
    chk("pre_reset_status", rd, 32'h1);
    spi_xfer(0, 8'h5C, 4, 1'b1, got);
    resetn = 1'b0;
    wait_clk(2);
    chk("midreset_outs", {27'b0, ready[0], |rdata[0], miso[0], miso_oe[0], irq[0]}, 32'h0);
    resetn = 1'b1;
    wait_clk(2);
    spi_xfer(0, 8'hFF, 8, 1'b1, got);
    chk("unarmed_oe", {31'b0, miso_oe[0]}, 32'h0);
    bus(0, 4'h4, 1'b0, 32'h0, rd);
    chk("unarmed_status", rd, 32'h0);
    ss_n[0] = 1'b1;
    wait_clk(6);
    spi_xfer(0, 8'h42, 8, 1'b0, got);
    bus(0, 4'h0, 1'b0, 32'h0, rd);
    chk("rearmed_data", rd, 32'h42);

    // Unmapped address reads zero
    bus(0, 4'h8, 1'b0, 32'h0, rd);
    chk("unmapped_read", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
